mul16_seq_ctrl: RTL and testbench
=================================

// Module: mul16_seq_ctrl
// PURPOSE
//  Iterative 16x16 multiply controller. Reuses one external 8x8 Booth tile
//  (the sign-extended partial-product multiplier) over four passes, then
//  accumulates the shifted 8x8 products into an exact 32-bit signed or
//  unsigned product.
//  Sits between the posit FMAU mantissa stage and the multiplier tile.
//  Valid/ready on both sides.
// PARAMETERS
//  MUL_LAT  1  tile latency in cycles, issue to mul_p valid; legal 0..3 (0 = combinational tile)
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset; synchronous, active-high
//  in_valid   in   1   operand request
//  in_ready   out  1   controller idle, can accept
//  op_a       in   16  multiplicand
//  op_b       in   16  multiplier
//  op_signed  in   1   1 = two's-complement operands, 0 = unsigned
//  mul_valid  out  1   tile issue strobe, one per pass
//  mul_a      out  8   tile operand A (byte of op_a)
//  mul_b      out  8   tile operand B (byte of op_b)
//  mul_a_sgn  out  1   treat mul_a as signed (high byte and op_signed)
//  mul_b_sgn  out  1   treat mul_b as signed (high byte and op_signed)
//  mul_p      in   18  tile product, two's complement, valid MUL_LAT cycles after issue
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  result     out  32  product modulo 2^32, exact for both modes
// BEHAVIOUR
//  Reset: in_ready=1; out_valid=0; mul_valid=0; result=0; mul_a/mul_b/mul_*_sgn=0.
//    Accumulator, pass counter and return-valid shift register are cleared.
//  FSM IDLE->ISSUE->DRAIN->DONE->IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready (cycle 0), latch op_a, op_b, op_signed
//    and clear acc; go to ISSUE.
//  - ISSUE: cycles 1..4 issue one pass per cycle with mul_valid=1, in this order:
//      (a[7:0],b[7:0]) sh0, (a[15:8],b[7:0]) sh8, (a[7:0],b[15:8]) sh8,
//      (a[15:8],b[15:8]) sh16.
//    Low bytes are always unsigned. High bytes are signed iff op_signed.
//  - A MUL_LAT-deep shift register tracks each issue and its shift amount.
//    On each return: acc <= acc + (sext32(mul_p) << sh), modulo 2^32.
//    With MUL_LAT=0, mul_p is added in the same cycle as its issue.
//  - DRAIN: waits for all four returns. With MUL_LAT=0 it is skipped.
//  - DONE: out_valid=1 from cycle 5+MUL_LAT; result=acc.
//    result and out_valid hold stable until out_valid&&out_ready.
//    The next cycle returns to IDLE with out_valid=0.
//  Latency: accept to out_valid = 5+MUL_LAT cycles.
//    Throughput is one op per 6+MUL_LAT cycles with no back-to-back overlap.
//  in_ready=0 everywhere outside IDLE; in_valid is ignored there.
//  Operands are captured at accept; later changes on op_* have no effect.
//  mul_valid=0 outside ISSUE. mul_p is sampled only when the tracked return
//    bit is set.
//  rst mid-op, in any state: everything is cleared next cycle. No out_valid
//    for the aborted op. Tile returns still in flight are discarded, because
//    the tracking shift register is cleared.
// CONFIGURATION
//  MUL16_ZERO_BYPASS_EN defined:
//  - At accept, if op_a==0 or op_b==0, go straight to DONE with acc=0.
//  - out_valid is asserted at cycle 1 and no tile passes are issued.
//  - Non-zero operands behave as above.
//  Macro undefined: every op takes all four passes; no zero-detect logic.
// TESTING
//  1. signed: a=0xFFFF, b=0xFFFF -> result=0x00000001.
//     out_valid at cycle 5+MUL_LAT; exactly 4 mul_valid pulses.
//  2. signed: a=0x8000, b=0x8000 -> 0x40000000.
//     signed: a=0x8000, b=0x7FFF -> 0xC0008000.
//  3. unsigned: a=0xFFFF, b=0xFFFF -> 0xFFFE0001.
//     Pass-2 mul_a_sgn=0 and mul_b_sgn=0.
//  4. Backpressure: out_ready=0 for 5 cycles after out_valid.
//     result and out_valid stay stable; in_ready=0; an in_valid pulse is
//     not accepted.
//  5. rst at ISSUE pass 2: the next cycle has in_ready=1 and out_valid=0.
//     A new op 3*-5 (signed) then yields 0xFFFFFFF1 with no stale
//     contribution.
//  6. Run each test with MUL_LAT=0 and MUL_LAT=3.
//     With MUL16_ZERO_BYPASS_EN: a=0, b=0x1234 -> 0 at cycle 1 with no
//     mul_valid pulses.
//     Without the macro: same operands -> 0 at cycle 5+MUL_LAT.

Source files
------------

// File: rtl/mul16_seq_ctrl.sv
// mul16_seq_ctrl: 16x16 signed/unsigned multiply built from four passes through
// one external 8x8 tile. Byte products are sign-extended, shifted by 0/8/16 and
// accumulated modulo 2^32. MUL_LAT sets the tile latency (0 = combinational tile).
// Optional build macro MUL16_ZERO_BYPASS_EN: a zero operand skips the tile passes
// and completes with a zero result one cycle after accept.
module mul16_seq_ctrl #(
    parameter int MUL_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        op_a,
    input  logic [15:0]        op_b,
    input  logic               op_signed,
    output logic               mul_valid,
    output logic [7:0]         mul_a,
    output logic [7:0]         mul_b,
    output logic               mul_a_sgn,
    output logic               mul_b_sgn,
    input  logic signed [17:0] mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [15:0]        opa_p0;
    logic [15:0]        opb_p0;
    logic               sgn_p0;
    logic signed [31:0] acc_p1;
    logic [1:0]         pass_cnt;
    logic [2:0]         ret_cnt;
    logic               accept;
    logic               iss_vld;
    logic [1:0]         iss_sh;
    logic               ret_vld;
    logic [1:0]         ret_sh;

    // Sign-extend a tile product to 32 bits and align it to its byte position
    // (sh: 0 -> x1, 1 -> x2^8, 2 -> x2^16).
    function automatic logic signed [31:0] align_pp(input logic signed [17:0] p,
                                                    input logic [1:0] sh);
        logic signed [31:0] ext;
        ext = 32'(p);
        case (sh)
            2'd1:    return ext <<< 8;
            2'd2:    return ext <<< 16;
            default: return ext;
        endcase
    endfunction

    // Two's-complement accumulate that wraps modulo 2^32; the wrap is what makes
    // the unsigned-mode result exact as well.
    function automatic logic signed [31:0] acc_wrap(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        logic signed [32:0] s;
        s = 33'(a) + 33'(b);
        return s[31:0];
    endfunction

    assign accept  = in_valid && in_ready;
    assign iss_vld = (state == ISSUE);
    // pass_cnt bit0 selects the high byte of A, bit1 the high byte of B.
    assign iss_sh  = {1'b0, pass_cnt[0]} + {1'b0, pass_cnt[1]};
    assign result  = $unsigned(acc_p1);

`ifdef MUL16_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (op_a == 16'd0) || (op_b == 16'd0);
`endif

    // Return tracking: each issue and its shift travel MUL_LAT cycles to meet mul_p.
    generate
        if (MUL_LAT == 0) begin : g_trk_comb
            assign ret_vld = iss_vld;
            assign ret_sh  = iss_sh;
        end else begin : g_trk_pipe
            logic [MUL_LAT-1:0] vld_trk;
            logic [1:0]         sh_trk [MUL_LAT];

            // Valid bits are control and are cleared by reset, dropping in-flight returns.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_trk <= '0;
                end else begin
                    vld_trk[0] <= iss_vld;
                    for (int i = 1; i < MUL_LAT; i++) begin
                        vld_trk[i] <= vld_trk[i-1];
                    end
                end
            end

            // Shift amounts ride alongside the valid bits; only used when valid.
            always_ff @(posedge clk) begin
                sh_trk[0] <= iss_sh;
                for (int i = 1; i < MUL_LAT; i++) begin
                    sh_trk[i] <= sh_trk[i-1];
                end
            end

            assign ret_vld = vld_trk[MUL_LAT-1];
            assign ret_sh  = sh_trk[MUL_LAT-1];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake/tile outputs; tile operands are forced to zero
    // outside ISSUE so the tile bus is quiet when idle.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_valid = 1'b0;
        mul_a     = 8'd0;
        mul_b     = 8'd0;
        mul_a_sgn = 1'b0;
        mul_b_sgn = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef MUL16_ZERO_BYPASS_EN
                    state_nx = zero_op ? DONE : ISSUE;
`else
                    state_nx = ISSUE;
`endif
                end
            end
            ISSUE: begin
                mul_valid = 1'b1;
                mul_a     = pass_cnt[0] ? opa_p0[15:8] : opa_p0[7:0];
                mul_b     = pass_cnt[1] ? opb_p0[15:8] : opb_p0[7:0];
                mul_a_sgn = sgn_p0 & pass_cnt[0];
                mul_b_sgn = sgn_p0 & pass_cnt[1];
                if (pass_cnt == 2'd3) begin
                    state_nx = (MUL_LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (ret_vld && (ret_cnt == 3'd3)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pass and return counters, restarted on every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= 2'd0;
            ret_cnt  <= 3'd0;
        end else if (accept) begin
            pass_cnt <= 2'd0;
            ret_cnt  <= 3'd0;
        end else begin
            if (iss_vld) pass_cnt <= pass_cnt + 2'd1;
            if (ret_vld) ret_cnt  <= ret_cnt + 3'd1;
        end
    end

    // Stage p0: capture operands at accept so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa_p0 <= op_a;
            opb_p0 <= op_b;
            sgn_p0 <= op_signed;
        end
    end

    // Stage p1: accumulate aligned tile products as their returns arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p1 <= '0;
        end else if (accept) begin
            acc_p1 <= '0;
        end else if (ret_vld) begin
            acc_p1 <= acc_wrap(acc_p1, align_pp(mul_p, ret_sh));
        end
    end

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// tb_mul16_seq_ctrl: directed bench driving two controllers (tile latency 0 and 3),
// each attached to a behavioural 8x8 signed/unsigned tile model.
module tb_mul16_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] op_a      [2];
    logic [15:0] op_b      [2];
    logic        op_signed [2];
    logic        mul_valid [2];
    logic [7:0]  mul_a     [2];
    logic [7:0]  mul_b     [2];
    logic        mul_a_sgn [2];
    logic        mul_b_sgn [2];
    logic [17:0] mul_p     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] result    [2];

    int nchk = 0;
    int nerr = 0;

    mul16_seq_ctrl #(.MUL_LAT(0)) u_l0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op_a(op_a[0]), .op_b(op_b[0]), .op_signed(op_signed[0]),
        .mul_valid(mul_valid[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]),
        .mul_a_sgn(mul_a_sgn[0]), .mul_b_sgn(mul_b_sgn[0]), .mul_p(mul_p[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0])
    );

    mul16_seq_ctrl #(.MUL_LAT(3)) u_l3 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op_a(op_a[1]), .op_b(op_b[1]), .op_signed(op_signed[1]),
        .mul_valid(mul_valid[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]),
        .mul_a_sgn(mul_a_sgn[1]), .mul_b_sgn(mul_b_sgn[1]), .mul_p(mul_p[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1])
    );

    // 8x8 tile: each byte extended to 9 bits (sign or zero), 18-bit product.
    function automatic logic [17:0] tile(input logic [7:0] a, input logic [7:0] b,
                                         input logic as, input logic bs);
        logic signed [8:0]  ea;
        logic signed [8:0]  eb;
        logic signed [17:0] p;
        ea = $signed({as & a[7], a});
        eb = $signed({bs & b[7], b});
        p  = 18'(ea) * 18'(eb);
        return p;
    endfunction

    // Combinational tile for the latency-0 controller.
    always_comb mul_p[0] = tile(mul_a[0], mul_b[0], mul_a_sgn[0], mul_b_sgn[0]);

    // Three-stage tile for the latency-3 controller.
    logic [17:0] t1, t2, t3;
    always @(posedge clk) begin
        t1 <= tile(mul_a[1], mul_b[1], mul_a_sgn[1], mul_b_sgn[1]);
        t2 <= t1;
        t3 <= t2;
    end
    assign mul_p[1] = t3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one op starting at a negedge; returns at a negedge with the DUT idle.
    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [31:0] exp, input int exp_lat,
                          input int exp_pulses, input int hold, input string tag);
        int   cyc;
        int   pulses;
        logic got;
        logic [1:0] s2;
        logic [1:0] s4;
        s2 = 2'bxx;
        s4 = 2'bxx;
        chk({tag, " in_ready"}, 32'(in_ready[d]), 32'd1);
        op_a[d] = a; op_b[d] = b; op_signed[d] = s; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0; op_a[d] = 16'hDEAD; op_b[d] = 16'hBEEF; op_signed[d] = ~s;
        cyc = 1; pulses = 0; got = 1'b0;
        while (cyc <= 20 && !got) begin
            if (out_valid[d]) begin
                got = 1'b1;
            end else begin
                if (mul_valid[d]) begin
                    if (pulses == 1) s2 = {mul_a_sgn[d], mul_b_sgn[d]};
                    if (pulses == 3) s4 = {mul_a_sgn[d], mul_b_sgn[d]};
                    pulses++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, " done"},   32'(got), 32'd1);
        chk({tag, " lat"},    32'(cyc), 32'(exp_lat));
        chk({tag, " pulses"}, 32'(pulses), 32'(exp_pulses));
        chk({tag, " result"}, result[d], exp);
        if (exp_pulses == 4) begin
            chk({tag, " sgn2"}, 32'(s2), 32'({s, 1'b0}));
            chk({tag, " sgn4"}, 32'(s4), 32'({s, s}));
        end
        for (int k = 0; k < hold; k++) begin
            chk({tag, " hold ov"},  32'(out_valid[d]), 32'd1);
            chk({tag, " hold res"}, result[d], exp);
            chk({tag, " hold ir"},  32'(in_ready[d]), 32'd0);
            if (k == 1) begin
                in_valid[d] = 1'b1; op_a[d] = 16'h0001; op_b[d] = 16'h0001;
            end else begin
                in_valid[d] = 1'b0;
            end
            @(negedge clk);
        end
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        chk({tag, " rel ov"}, 32'(out_valid[d]), 32'd0);
        chk({tag, " rel ir"}, 32'(in_ready[d]), 32'd1);
        if (hold > 0) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                chk({tag, " no accept mv"}, 32'(mul_valid[d]), 32'd0);
                chk({tag, " no accept ov"}, 32'(out_valid[d]), 32'd0);
            end
        end
    endtask

    initial begin
        int lat;
        int zlat;
        int zpul;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; op_a[d] = '0; op_b[d] = '0;
            op_signed[d] = 1'b0; out_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 0 : 3;
            chk("rst in_ready",  32'(in_ready[d]),  32'd1);
            chk("rst out_valid", 32'(out_valid[d]), 32'd0);
            chk("rst mul_valid", 32'(mul_valid[d]), 32'd0);
            chk("rst result",    result[d],         32'd0);
            chk("rst mul_a",     32'(mul_a[d]),     32'd0);
            chk("rst mul_b",     32'(mul_b[d]),     32'd0);
            chk("rst sgn",       32'({mul_a_sgn[d], mul_b_sgn[d]}), 32'd0);
            rst[d] = 1'b0;

            run_op(d, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 5 + lat, 4, 0, "s_m1_m1");
            run_op(d, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 5 + lat, 4, 0, "s_min_min");
            run_op(d, 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 5 + lat, 4, 0, "s_min_max");
            run_op(d, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 5 + lat, 4, 0, "u_max_max");
            run_op(d, 16'h0003, 16'h0005, 1'b0, 32'h0000000F, 5 + lat, 4, 5, "u_backpr");

            // Abort an op with reset during its second pass.
            op_a[d] = 16'h7FFF; op_b[d] = 16'h7FFF; op_signed[d] = 1'b1; in_valid[d] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid[d] = 1'b0;
            @(negedge clk);
            chk("abort pass2 mv", 32'(mul_valid[d]), 32'd1);
            rst[d] = 1'b1;
            @(negedge clk);
            rst[d] = 1'b0;
            chk("abort in_ready",  32'(in_ready[d]),  32'd1);
            chk("abort out_valid", 32'(out_valid[d]), 32'd0);
            chk("abort mul_valid", 32'(mul_valid[d]), 32'd0);
            run_op(d, 16'h0003, 16'hFFFB, 1'b1, 32'hFFFFFFF1, 5 + lat, 4, 0, "s_after_rst");

`ifdef MUL16_ZERO_BYPASS_EN
            zlat = 1;
            zpul = 0;
`else
            zlat = 5 + lat;
            zpul = 4;
`endif
            run_op(d, 16'h0000, 16'h1234, 1'b0, 32'h00000000, zlat, zpul, 0, "zero_a");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
